// File: rtl/sdram_device_model.sv
// sdram_device_model
//   Cycle-accurate responder model of a 16-bit SDR SDRAM (MT48LC16M16 subset).
//   It decodes the command pins, tracks per-bank open rows and the mode register,
//   services READ/WRITE bursts with CAS latency and DQM write masking, flags
//   protocol violations and offers a backdoor port into the memory array.
//
// Ports
//   clk, reset             model clock, synchronous active-high reset
//   cs_n/ras_n/cas_n/we_n  command pins, sampled on every rising edge
//   ba, a                  bank address and multiplexed row/column address
//   dqm, dq_in             write byte masks (1 = masked) and write data
//   dq_out, dq_oe          registered read data and its drive enable
//   bd_we/bd_addr/bd_wdata backdoor write, word address {bank,row,col}
//   bd_rdata               backdoor read, combinational from bd_addr
//   err, err_code          sticky error flag and code of the first error
//   refresh_cnt            count of AUTO_REFRESH commands (wraps)
module sdram_device_model #(
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 9,
  parameter int TRCD     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cs_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [1:0]                       ba,
  input  logic [12:0]                      a,
  input  logic [1:0]                       dqm,
  input  logic [15:0]                      dq_in,
  output logic [15:0]                      dq_out,
  output logic                             dq_oe,
  input  logic                             bd_we,
  input  logic [2+ROW_BITS+COL_BITS-1:0]   bd_addr,
  input  logic [15:0]                      bd_wdata,
  output logic [15:0]                      bd_rdata,
  output logic                             err,
  output logic [2:0]                       err_code,
  output logic [15:0]                      refresh_cnt
);

  localparam int AW = 2 + ROW_BITS + COL_BITS;
  localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  // Column of burst word idx: sequential order, wrapping inside the
  // BL-aligned block that contains the start column.
  function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] start,
                                                    input logic [3:0]          idx,
                                                    input logic [3:0]          len);
    logic [COL_BITS-1:0] mask;
    mask = COL_BITS'(len - 4'd1);
    return (start & ~mask) | ((start + COL_BITS'(idx)) & mask);
  endfunction

  logic [15:0] mem [0:(1<<AW)-1];

  // Mode register (only the fields the model uses)
  logic [1:0]  mode_bl_q;
  logic        mode_cl3_q;
  logic        mode_wsingle_q;
  logic        mode_valid_q;

  // Bank state
  logic [3:0]          open_q, open_d;
  logic [ROW_BITS-1:0] row_q  [4];
  logic [TW-1:0]       trcd_q [4];

  // Error / refresh state
  logic        err_q;
  logic [2:0]  err_code_q;
  logic [15:0] refresh_q;

  // Write burst state
  logic                wr_pend_q;
  logic [3:0]          wr_idx_q, wr_len_q;
  logic [1:0]          wr_bank_q;
  logic [ROW_BITS-1:0] wr_row_q;
  logic [COL_BITS-1:0] wr_col_q;
  logic                wr_ap_q;

  // Read burst state
  logic                rd_pend_q, rd_wait_q;
  logic [3:0]          rd_idx_q, rd_len_q;
  logic [1:0]          rd_bank_q;
  logic [ROW_BITS-1:0] rd_row_q;
  logic [COL_BITS-1:0] rd_col_q;
  logic                rd_ap_q;
  logic [15:0]         dq_out_q;
  logic                dq_oe_q;

  // Decode
  cmd_e        cmd;
  logic [2:0]  code;
  logic        rd_ok, wr_ok, brk;
  logic [3:0]  bl_len, wr_len;
  logic        host_we;
  logic [AW-1:0] host_addr, rd_addr;
  logic [3:0]  ap_close;

  assign bl_len = 4'd1 << mode_bl_q;
  assign wr_len = mode_wsingle_q ? 4'd1 : bl_len;

  // Command classification and error code; within one command the checks
  // are ordered so the lowest applicable code wins.
  always_comb begin
    cmd  = cs_n ? CMD_NOP : cmd_e'({ras_n, cas_n, we_n});
    code = 3'd0;
    case (cmd)
      CMD_MRS: if (a[2:0] > 3'd3 || (a[6:4] != 3'd2 && a[6:4] != 3'd3)) code = 3'd6;
      CMD_ACT: if (open_q[ba]) code = 3'd3;
      CMD_RD, CMD_WR: begin
        if (!mode_valid_q)           code = 3'd1;
        else if (!open_q[ba])        code = 3'd2;
        else if (trcd_q[ba] != '0)   code = 3'd4;
      end
      CMD_REF: if (|open_q) code = 3'd5;
      default: code = 3'd0;
    endcase
    rd_ok = (cmd == CMD_RD) && (code == 3'd0);
    wr_ok = (cmd == CMD_WR) && (code == 3'd0);
    // Erroneous READ/WRITE are ignored entirely, so they do not interrupt.
    brk   = rd_ok || wr_ok || (cmd == CMD_BST);
  end

  // Host write port and auto-precharge closures for this edge
  always_comb begin
    host_we   = 1'b0;
    host_addr = '0;
    ap_close  = 4'b0000;
    rd_addr   = {rd_bank_q, rd_row_q, burst_col(rd_col_q, rd_idx_q, rd_len_q)};
    if (wr_ok) begin
      host_we   = 1'b1;
      host_addr = {ba, row_q[ba], a[COL_BITS-1:0]};
      if (wr_len == 4'd1 && a[10]) ap_close[ba] = 1'b1;
    end else if (wr_pend_q && !brk) begin
      host_we   = 1'b1;
      host_addr = {wr_bank_q, wr_row_q, burst_col(wr_col_q, wr_idx_q, wr_len_q)};
      if (wr_ap_q && wr_idx_q == wr_len_q - 4'd1) ap_close[wr_bank_q] = 1'b1;
    end
    // A read burst closes its bank at the edge that fetches its last word.
    if (rd_pend_q && !brk && !rd_wait_q && rd_ap_q && rd_idx_q == rd_len_q - 4'd1)
      ap_close[rd_bank_q] = 1'b1;
  end

  always_comb begin
    open_d = open_q & ~ap_close;
    if (cmd == CMD_ACT && code == 3'd0) open_d[ba] = 1'b1;
    if (cmd == CMD_PRE) begin
      if (a[10]) open_d = 4'b0000;
      else       open_d[ba] = 1'b0;
    end
  end

  // Control state: banks, mode, errors, refresh count
  always_ff @(posedge clk) begin
    if (reset) begin
      open_q         <= 4'b0000;
      mode_valid_q   <= 1'b0;
      mode_bl_q      <= 2'd0;
      mode_cl3_q     <= 1'b0;
      mode_wsingle_q <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= 3'd0;
      refresh_q      <= 16'd0;
      for (int b = 0; b < 4; b++) trcd_q[b] <= '0;
    end else begin
      open_q <= open_d;
      for (int b = 0; b < 4; b++)
        if (trcd_q[b] != '0) trcd_q[b] <= trcd_q[b] - TW'(1);
      if (cmd == CMD_ACT && code == 3'd0) trcd_q[ba] <= TW'(TRCD - 1);
      // An invalid LOAD_MODE leaves the previous mode in place.
      if (cmd == CMD_MRS && code == 3'd0) begin
        mode_bl_q      <= a[1:0];
        mode_cl3_q     <= a[4];
        mode_wsingle_q <= a[9];
        mode_valid_q   <= 1'b1;
      end
      if (cmd == CMD_REF) refresh_q <= refresh_q + 16'd1;
      if (code != 3'd0 && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cmd == CMD_ACT && code == 3'd0) row_q[ba] <= a[ROW_BITS-1:0];
  end

  // Write burst sequencing; word 0 is taken at the command edge itself
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend_q <= 1'b0;
      wr_idx_q  <= 4'd0;
    end else if (wr_ok) begin
      wr_pend_q <= (wr_len != 4'd1);
      wr_idx_q  <= 4'd1;
    end else if (brk) begin
      wr_pend_q <= 1'b0;
    end else if (wr_pend_q) begin
      if (wr_idx_q == wr_len_q - 4'd1) wr_pend_q <= 1'b0;
      wr_idx_q <= wr_idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      wr_bank_q <= ba;
      wr_row_q  <= row_q[ba];
      wr_col_q  <= a[COL_BITS-1:0];
      wr_len_q  <= wr_len;
      wr_ap_q   <= a[10];
    end
  end

  // Read burst sequencing; word i is driven after edge N+CL-1+i so the host
  // samples it at edge N+CL+i. A new READ/WRITE/BST drops what remains.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_wait_q <= 1'b0;
      rd_idx_q  <= 4'd0;
      dq_oe_q   <= 1'b0;
      dq_out_q  <= 16'd0;
    end else begin
      dq_oe_q  <= 1'b0;
      dq_out_q <= 16'd0;
      if (rd_ok) begin
        rd_pend_q <= 1'b1;
        rd_wait_q <= mode_cl3_q;
        rd_idx_q  <= 4'd0;
      end else if (brk) begin
        rd_pend_q <= 1'b0;
      end else if (rd_pend_q) begin
        if (rd_wait_q) begin
          rd_wait_q <= 1'b0;
        end else begin
          dq_out_q <= mem[rd_addr];
          dq_oe_q  <= 1'b1;
          rd_idx_q <= rd_idx_q + 4'd1;
          if (rd_idx_q == rd_len_q - 4'd1) rd_pend_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ok) begin
      rd_bank_q <= ba;
      rd_row_q  <= row_q[ba];
      rd_col_q  <= a[COL_BITS-1:0];
      rd_len_q  <= bl_len;
      rd_ap_q   <= a[10];
    end
  end

  // Memory array; host bytes are assigned after the backdoor word so that a
  // coincident host write to the same word wins on every unmasked byte.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (host_we) begin
      if (!dqm[0]) mem[host_addr][7:0]  <= dq_in[7:0];
      if (!dqm[1]) mem[host_addr][15:8] <= dq_in[15:8];
    end
  end

  assign bd_rdata    = mem[bd_addr];
  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign refresh_cnt = refresh_q;

endmodule
